// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide sequencer owning HI/LO, stalling the core while busy.
module md_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, step, p_fix;
  logic [31:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, q_fix, r_fix;
  logic mul_q, mul_d, neg_q, neg_d, rneg_q, rneg_d, busy_q, busy_d;
  logic launch, sgn, is_mul;
  logic [32:0] sum;
  logic [33:0] diff;
  always_comb begin
    launch = state_q == IDLE && mdc inside {[3'd1:3'd4]};
    sgn = mdc == 3'd1 || mdc == 3'd3;
    is_mul = mdc == 3'd1 || mdc == 3'd2;
    mag_a = sgn && a[31] ? -a : a;
    mag_b = sgn && b[31] ? -b : b;
    // acc holds product:multiplier for MUL, remainder:quotient for DIV
    sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    diff = {1'b0, acc_q[63:31]} - {2'b0, opnd_q};
    step = mul_q ? {sum, acc_q[31:1]}
         : diff[33] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    p_fix = neg_q ? -step : step;
    q_fix = neg_q ? -step[31:0] : step[31:0];
    r_fix = rneg_q ? -step[63:32] : step[63:32];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opnd_d = opnd_q;
    mul_d = mul_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = BUSY;
          cnt_d = 6'd0;
          acc_d = {32'd0, mag_a};
          opnd_d = mag_b;
          mul_d = is_mul;
          // divide-by-zero quotient stays all ones regardless of signs
          neg_d = sgn && (a[31] ^ b[31]) && (is_mul || b != 32'd0);
          rneg_d = sgn && a[31] && !is_mul;
        end
        hi_d = mdc == 3'd5 ? a : hi_q;
        lo_d = mdc == 3'd6 ? a : lo_q;
      end
      BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          hi_d = mul_q ? p_fix[63:32] : r_fix;
          lo_d = mul_q ? p_fix[31:0] : q_fix;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 6'd0;
      acc_q <= 64'd0;
      opnd_q <= 32'd0;
      mul_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opnd_q <= opnd_d;
      mul_q <= mul_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
    end
  end
  assign stall = !reset && (launch || state_q == BUSY);
  assign busy = busy_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: table-driven scoreboard bench for the multiply/divide sequencer.
module tb_md_seq;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] mdc = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic stall, busy;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  typedef struct {logic [2:0] mdc; logic [31:0] a, b, hi, lo;} vec_t;
  vec_t vt[10];
  logic [63:0] sb[$];
  md_seq dut (.clk(clk), .reset(reset), .mdc(mdc), .a(a), .b(b),
              .stall(stall), .busy(busy), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // drives one MUL/DIV, holds mdc while stalled, drives dm during DONE
  task automatic op(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y,
                    input logic [2:0] dm);
    int n;
    logic [31:0] h0, l0;
    logic [63:0] e;
    logic chg;
    @(negedge clk);
    mdc = m; a = x; b = y;
    #1;
    h0 = hi; l0 = lo; chg = 1'b0; n = 0; e = 64'd0;
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
      a = $urandom; b = $urandom;
      #1;
      if (stall && (hi !== h0 || lo !== l0)) chg = 1'b1;
    end
    chk("stall_cycles", 64'(n), 64'd33);
    chk("hilo_held", 64'(chg), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
    if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk("hi", 64'(hi), 64'(e[63:32]));
      chk("lo", 64'(lo), 64'(e[31:0]));
    end
    mdc = dm; a = $urandom;
    #1 chk("stall_done", 64'(stall), 64'd0);
    @(negedge clk);
    mdc = 3'd0;
    #1;
    chk("busy_after", 64'(busy), 64'd0);
    chk("hilo_kept", {hi, lo}, e);
  endtask
  initial begin
    vt[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
    vt[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3};
    vt[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vt[5] = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    vt[6] = '{3'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[7] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[8] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[9] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    mdc = 3'd1;
    repeat (2) @(negedge clk);
    #1 chk("stall_in_reset", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0; mdc = 3'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_hilo", {hi, lo}, 64'd0);
      chk("idle_ctl", 64'({stall, busy}), 64'd0);
    end
    for (int i = 0; i < 10; i++) begin
      sb.push_back({vt[i].hi, vt[i].lo});
      op(vt[i].mdc, vt[i].a, vt[i].b, i == 2 ? 3'd5 : i == 3 ? 3'd6 : vt[i].mdc);
    end
    @(negedge clk);
    mdc = 3'd5; a = 32'hCAFEBABE;
    #1 chk("mthi_stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1 chk("mthi_hi", 64'(hi), 64'hCAFEBABE);
    mdc = 3'd6; a = 32'h0BADF00D;
    #1 chk("mtlo_stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1 chk("mtlo_hilo", {hi, lo}, 64'hCAFEBABE_0BADF00D);
    mdc = 3'd1; a = 32'd5; b = 32'd7;
    repeat (10) @(negedge clk);
    #1 chk("busy_mid", 64'({stall, busy}), 64'd3);
    reset = 1'b1; mdc = 3'd0;
    #1 chk("stall_reset", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_ctl", 64'({stall, busy}), 64'd0);
    sb.push_back(64'd35);
    op(3'd1, 32'd5, 32'd7, 3'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_seq.md
# md_seq

Multi-cycle multiply/divide sequencer that owns the HI/LO registers for the single-cycle MIPS core. It replaces combinational mul/div with a 32-iteration shift-add multiplier and restoring divider. It holds the PC via `stall` while an operation is in flight, then lets the issuing instruction retire exactly once. It sits beside the register file, fed from rs/rt read data and the controller's `mdc` code.

## Interface
- Parameters: none (datapath fixed at 32 bits, 32 iterations).
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mdc`  in  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- `a`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `b`  in  32  rt operand (divisor / multiplier).
- `stall`  out  1  hold PC and instruction; combinational.
- `busy`  out  1  registered, high in BUSY or DONE.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, BUSY, DONE; 6-bit iteration counter `cnt`.
- IDLE:
  - `mdc` in 001–100: latch op, signedness, |a|, |b| (signed ops take magnitudes) and the result-sign flags; `cnt`=0; go to BUSY.
  - `mdc`=101: hi<=a. `mdc`=110: lo<=a. Stay IDLE, no stall.
  - Other codes: no action.
- BUSY: one iteration per cycle; `cnt` increments.
  - Multiply: 64-bit product/multiplier shift-add on magnitudes.
  - Divide: restoring; shift remainder:quotient left 1, subtract divisor magnitude, keep the result if non-negative and set the quotient bit.
  - At `cnt`=31 the iteration completes and hi/lo are written with sign-corrected results; go to DONE.
- Sign rules:
  - MULT: negate the 64-bit product if a[31]^b[31]; hi=product[63:32], lo=product[31:0].
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend; lo=quotient, hi=remainder.
  - Unsigned ops: no correction.
- DONE: `mdc` fully ignored, including MTHI/MTLO, because it is still the same instruction; go to IDLE.
- Division by zero: no exception, normal latency; lo=32'hFFFFFFFF, hi=a (DIVU and DIV alike).
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no exception.
- HI/LO are unchanged by MUL/DIV until the final BUSY edge; an aborted op leaves no partial result.

## Timing
- `stall` = !reset && ((IDLE && mdc in 001–100) || BUSY). It is low in DONE, so the instruction retires in DONE.
- MUL/DIV: launch in IDLE cycle T with `stall`=1. BUSY runs T+1..T+32 with `stall`=1. DONE is T+33 with `stall`=0. Next IDLE is T+34.
- Total 33 stall cycles per MUL/DIV. New hi/lo are visible from T+33 (an MFHI/MFLO after it sees the result).
- MTHI/MTLO: 0 stall cycles, value visible the next cycle.
- `busy` is registered: 0 at T, 1 at T+1..T+33.
- Reset (any state, including mid-BUSY): next edge gives state IDLE, cnt=0, hi=0, lo=0, busy=0. `stall`=0 while reset is high.
- Operands change during BUSY: ignored, since only the values latched at launch are used.
- Back-to-back MUL/DIV instructions: the second launches in the IDLE cycle after DONE, with no overlap.

## Test plan
- Reset, then idle with `mdc`=000 -> hi=lo=0, stall=0, busy=0 for 10 cycles.
- MULT a=0xFFFFFFFE (-2), b=3 -> stall high for exactly 33 cycles; from DONE, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, 33 stall cycles, no hang.
- MTHI a=0xCAFEBABE, then MTLO a=0x0BADF00D -> stall never asserts; hi/lo update on consecutive cycles. Holding `mdc`=001 through DONE -> exactly one multiply executes.
- Reset asserted at the 10th BUSY cycle of MULT 5×7 -> next cycle IDLE, hi=lo=0, busy=0. MULT relaunched after reset -> lo=35, hi=0.
